prbs31_lock_ctrl: RTL and testbench
===================================

# prbs31_lock_ctrl

RX-side link check controller in the self-synchronous scrambler chain. It sits in the `clk_div_60` domain after the parallel descrambler. Each 60-bit descrambled word is checked against the PRBS31 recurrence (x^31 + x^28 + 1). A HUNT/LOCKED state machine qualifies link lock and detects loss of lock. Saturating bit-error and lock-loss counters are exported for bring-up and BER measurement.

## Interface
Parameters:
- `DATA_W`, 60, word width (fixed by the deserializer ratio).
- `LOCK_CNT`, 16, consecutive clean checked words required to declare lock.
- `WINDOW`, 64, length in checked words of the loss-of-lock observation window.
- `LOSS_THRESH`, 4, error words within one window that force loss of lock.
- `ERR_CNT_W`, 32, width of `bit_err_cnt`.

Ports:
- `clk_div_60`  in  1  word clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `chk_en`  in  1  checker enable; level-sensitive.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `data_descrambled`  in  DATA_W  descrambled word; bit 59 is the earliest bit on the line, bit 0 the latest.
- `lock`  out  1  high in LOCKED.
- `state`  out  2  encoding: 0 = IDLE, 1 = HUNT, 2 = LOCKED.
- `err_word`  out  1  one-cycle pulse per checked word with at least one error.
- `bit_err_cnt`  out  ERR_CNT_W  accumulated bit errors.
- `lock_loss_cnt`  out  8  number of LOCKED→HUNT transitions.

## Operation
- Pipeline:
  - Each edge with `chk_en`=1: `data_r` <= `data_descrambled` and `prev` <= `data_r`.
  - Valid flags `vld_r` and `vld_p` shift alongside the data.
  - A word is "checked" only when `vld_r` and `vld_p` are both set. The first word after enable is history only.
- Error vector, from c = {prev, data_r}, for i in 0..59: e[i] = c[i] ^ c[i+28] ^ c[i+31].
- Word error rules:
  - A word is an error word if e is nonzero.
  - A word is also an error word if `data_r` is all-zero. This guards against a dead link, which satisfies the recurrence.
- Bit-error count per checked word:
  - popcount(e), 0..60.
  - An all-zero word contributes DATA_W.
- FSM:
  - Any state with `chk_en`=0 → IDLE. Clears `vld_r`, `vld_p`, the run counter and the window counters. The two output counters hold.
  - IDLE with `chk_en`=1 → HUNT.
  - HUNT: the run counter increments on each clean checked word and clears on each error word. On reaching LOCK_CNT → LOCKED; the run counter clears.
  - LOCKED, window tracking: the window counter counts checked words; the window error counter counts error words.
  - LOCKED, loss of lock: when the window error counter reaches LOSS_THRESH → HUNT. `lock_loss_cnt` increments (saturating at 255) and both window counters clear.
  - LOCKED, window wrap: the word that completes WINDOW is evaluated inside the old window. Both window counters then clear.
- `bit_err_cnt` accumulates only in LOCKED, including the word that causes loss of lock. It saturates at all-ones, and an addition that would overflow clamps.
- `err_word` pulses in both HUNT and LOCKED.
- `cnt_clr`:
  - Clears `bit_err_cnt` and `lock_loss_cnt` on the next edge.
  - It wins over a simultaneous increment.
  - It has no effect on the FSM.

## Timing
- Reset (`rst_n`=0, asynchronous): `state`=IDLE, `lock`=0, `err_word`=0, `bit_err_cnt`=0, `lock_loss_cnt`=0, all internal counters and valid flags 0.
- Latency: a word presented before edge k is in `data_r` after edge k. Its `err_word`, counter update and state transition take effect at edge k+1.
- `lock` is registered, equal to (state==LOCKED), and has no combinational path from the inputs.
- Clean PRBS31 from the first edge with `chk_en`=1 (edge 1):
  - the first checked-word result lands at edge 3;
  - `lock` rises at edge LOCK_CNT+2 = 18.
- Deassertion of `chk_en` mid-LOCKED: `lock` falls at the next edge. Re-enabling requires a full re-hunt.
- Reset asserted mid-operation clears everything, including the saturated counters.

## Test plan
- Clean PRBS31 stream, `chk_en` raised at edge 1 → `lock`=1 at edge 18, `err_word` never pulses, `bit_err_cnt`=0 after 1000 words.
- Locked; flip bit 59 of one word → exactly 1 `err_word` pulse, `bit_err_cnt` +3, `lock` stays 1.
- Locked; flip bit 0 of one word → 2 consecutive `err_word` pulses, `bit_err_cnt` +3 in total, `lock` stays 1.
- Locked; 4 error words within 64 words → `state`=HUNT one edge after the 4th checked error word, `lock_loss_cnt`=1. Clean data afterwards → relock after 16 clean checked words.
- Locked; all-zero input → `err_word` on every word, `bit_err_cnt` +60 per word until loss of lock, then HUNT never relocks.
- `cnt_clr` asserted on the same edge as an error increment → `bit_err_cnt`=0. With `bit_err_cnt` preloaded near 2^32−1 by forced errors → the count holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/prbs31_lock_ctrl.sv
// PRBS31 (x^31 + x^28 + 1) link checker: HUNT/LOCKED lock qualification plus saturating BER counters.
// Latency: word captured at edge k; its err_word, counter update and state change land at edge k+1.
// Backpressure: none; every clock with chk_en=1 consumes one word.
module prbs31_lock_ctrl #(
    parameter int DATA_W      = 60,
    parameter int LOCK_CNT    = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 32
) (
    input  logic                 clk_div_60,
    input  logic                 rst_n,
    input  logic                 chk_en,
    input  logic                 cnt_clr,
    input  logic [DATA_W-1:0]    data_descrambled,
    output logic                 lock,
    output logic [1:0]           state,
    output logic                 err_word,
    output logic [ERR_CNT_W-1:0] bit_err_cnt,
    output logic [7:0]           lock_loss_cnt
);
    localparam int TAP_A  = 28;
    localparam int TAP_B  = 31;
    localparam int POP_W  = $clog2(DATA_W + 1);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);
    localparam int SUM_W  = ERR_CNT_W + 1;

    localparam logic [RUN_W-1:0]  RUN_LAST       = RUN_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST       = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] WERR_LAST      = WERR_W'(LOSS_THRESH - 1);
    localparam logic [POP_W-1:0]  ZERO_WORD_BITS = POP_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   data_r;
    logic [DATA_W-1:0]   prev;
    logic                vld_r;
    logic                vld_p;
    logic [RUN_W-1:0]    run_cnt;
    logic [WIN_W-1:0]    win_cnt;
    logic [WERR_W-1:0]   win_err;

    logic [2*DATA_W-1:0] chk_seq;
    logic [DATA_W-1:0]   err_vec;
    logic [POP_W-1:0]    err_pop;
    logic [POP_W-1:0]    bit_inc;
    logic [SUM_W-1:0]    err_sum;
    logic                zero_word;
    logic                word_chk;
    logic                word_err;
    logic                acc_en;
    logic                loss_evt;
    logic                win_end;

    // Higher index is earlier on the line, so taps reach upward into prev.
    always_comb begin
        chk_seq = {prev, data_r};
        err_vec = '0;
        for (int i = 0; i < DATA_W; i++) begin
            err_vec[i] = chk_seq[i] ^ chk_seq[i+TAP_A] ^ chk_seq[i+TAP_B];
        end
    end

    always_comb begin
        err_pop = '0;
        for (int i = 0; i < DATA_W; i++) begin
            err_pop = err_pop + POP_W'(err_vec[i]);
        end
    end

    // A dead (all-zero) link satisfies the recurrence; treat it as fully errored.
    assign zero_word = ~|data_r;
    assign word_chk  = chk_en & vld_r & vld_p;
    assign word_err  = zero_word | (|err_vec);
    assign bit_inc   = zero_word ? ZERO_WORD_BITS : err_pop;
    assign acc_en    = word_chk & (state_q == ST_LOCKED);
    assign loss_evt  = acc_en & word_err & (win_err == WERR_LAST);
    assign win_end   = (win_cnt == WIN_LAST);
    assign err_sum   = {1'b0, bit_err_cnt} + {{(SUM_W - POP_W){1'b0}}, bit_inc};

    always_ff @(posedge clk_div_60 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lock     <= 1'b0;
            err_word <= 1'b0;
            data_r   <= '0;
            prev     <= '0;
            vld_r    <= 1'b0;
            vld_p    <= 1'b0;
            run_cnt  <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
        end else begin
            err_word <= 1'b0;
            if (!chk_en) begin
                state_q <= ST_IDLE;
                lock    <= 1'b0;
                vld_r   <= 1'b0;
                vld_p   <= 1'b0;
                run_cnt <= '0;
                win_cnt <= '0;
                win_err <= '0;
            end else begin
                data_r <= data_descrambled;
                prev   <= data_r;
                vld_r  <= 1'b1;
                vld_p  <= vld_r;
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_HUNT;
                    end
                    ST_HUNT: begin
                        if (word_chk) begin
                            err_word <= word_err;
                            if (word_err) begin
                                run_cnt <= '0;
                            end else if (run_cnt == RUN_LAST) begin
                                state_q <= ST_LOCKED;
                                lock    <= 1'b1;
                                run_cnt <= '0;
                            end else begin
                                run_cnt <= run_cnt + RUN_W'(1);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (word_chk) begin
                            err_word <= word_err;
                            if (loss_evt) begin
                                state_q <= ST_HUNT;
                                lock    <= 1'b0;
                                win_cnt <= '0;
                                win_err <= '0;
                            end else if (win_end) begin
                                // The closing word was already judged in the old window.
                                win_cnt <= '0;
                                win_err <= '0;
                            end else begin
                                win_cnt <= win_cnt + WIN_W'(1);
                                win_err <= win_err + WERR_W'(word_err);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        lock    <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_div_60 or negedge rst_n) begin
        if (!rst_n) begin
            bit_err_cnt   <= '0;
            lock_loss_cnt <= '0;
        end else if (cnt_clr) begin
            bit_err_cnt   <= '0;
            lock_loss_cnt <= '0;
        end else begin
            if (acc_en) begin
                bit_err_cnt <= err_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
            end
            if (loss_evt && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_prbs31_lock_ctrl.sv
// Bench for prbs31_lock_ctrl: randomized PRBS31 traffic with injected errors against a word-level model.
// Latency: model updates once per clock edge, outputs sampled 1 time unit after the edge.
// Backpressure: none; one word is driven every clock.
module tb_prbs31_lock_ctrl;
    localparam int LOCK_CNT    = 16;
    localparam int WINDOW      = 64;
    localparam int LOSS_THRESH = 4;
    localparam int SAT_W       = 10;

    logic              clk_div_60 = 1'b0;
    logic              rst_n      = 1'b1;
    logic              chk_en     = 1'b0;
    logic              cnt_clr    = 1'b0;
    logic [59:0]       data_descrambled = '0;
    logic              lock;
    logic [1:0]        state;
    logic              err_word;
    logic [31:0]       bit_err_cnt;
    logic [7:0]        lock_loss_cnt;
    logic              s_lock;
    logic [1:0]        s_state;
    logic              s_err_word;
    logic [SAT_W-1:0]  s_bit_err_cnt;
    logic [7:0]        s_lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_div_60 = ~clk_div_60;

    prbs31_lock_ctrl dut (
        .clk_div_60(clk_div_60), .rst_n(rst_n), .chk_en(chk_en), .cnt_clr(cnt_clr),
        .data_descrambled(data_descrambled), .lock(lock), .state(state), .err_word(err_word),
        .bit_err_cnt(bit_err_cnt), .lock_loss_cnt(lock_loss_cnt)
    );

    // Narrow-counter twin on the same inputs so the saturating clamp is reachable in simulation.
    prbs31_lock_ctrl #(.ERR_CNT_W(SAT_W)) dut_sat (
        .clk_div_60(clk_div_60), .rst_n(rst_n), .chk_en(chk_en), .cnt_clr(cnt_clr),
        .data_descrambled(data_descrambled), .lock(s_lock), .state(s_state), .err_word(s_err_word),
        .bit_err_cnt(s_bit_err_cnt), .lock_loss_cnt(s_lock_loss_cnt)
    );

    // PRBS31 source: serial bit history, oldest first.
    bit gen_hist[$];

    function automatic logic [59:0] prbs_word();
        logic [59:0] w;
        w = '0;
        for (int k = 0; k < 60; k++) begin
            bit b;
            b = gen_hist[3] ^ gen_hist[0];
            gen_hist.push_back(b);
            void'(gen_hist.pop_front());
            w[59-k] = b;
        end
        return w;
    endfunction

    // Reference model: words seen since enable, in arrival order.
    int           m_state, m_run, m_wcnt, m_werr, m_loss;
    longint       m_bits;
    bit           m_err;
    logic [59:0]  m_hist[$];

    function automatic void judge(input logic [59:0] p, input logic [59:0] cur,
                                  output bit err, output int nbits);
        bit seq[120];
        for (int k = 0; k < 60; k++) begin
            seq[k]      = p[59-k];
            seq[60 + k] = cur[59-k];
        end
        nbits = 0;
        for (int t = 60; t < 120; t++) nbits += int'(seq[t] ^ seq[t-28] ^ seq[t-31]);
        err = (nbits != 0) || (cur == '0);
        if (cur == '0) nbits = 60;
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_wcnt = 0; m_werr = 0; m_loss = 0;
        m_bits = 0; m_err = 0; m_hist.delete();
    endtask

    task automatic model_edge(input bit en, input bit clr, input logic [59:0] w);
        bit we; int nb; int inc; bit lossev;
        m_err = 0; inc = 0; lossev = 0;
        if (!en) begin
            m_state = 0; m_hist.delete(); m_run = 0; m_wcnt = 0; m_werr = 0;
        end else begin
            if (m_hist.size() == 2 && m_state != 0) begin
                judge(m_hist[0], m_hist[1], we, nb);
                m_err = we;
                if (m_state == 1) begin
                    m_run = we ? 0 : m_run + 1;
                    if (m_run == LOCK_CNT) begin m_state = 2; m_run = 0; end
                end else begin
                    inc = nb; m_wcnt++; m_werr += int'(we);
                    if (m_werr == LOSS_THRESH) begin
                        m_state = 1; lossev = 1; m_wcnt = 0; m_werr = 0;
                    end else if (m_wcnt == WINDOW) begin
                        m_wcnt = 0; m_werr = 0;
                    end
                end
            end
            if (m_state == 0) m_state = 1;
            m_hist.push_back(w);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
        end
        if (clr) begin
            m_bits = 0; m_loss = 0;
        end else begin
            m_bits += inc;
            if (lossev && m_loss < 255) m_loss++;
        end
    endtask

    function automatic logic [31:0] exp_bits();
        return (m_bits > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_bits[31:0];
    endfunction

    function automatic logic [SAT_W-1:0] exp_sat();
        return (m_bits > 1023) ? 10'h3FF : m_bits[SAT_W-1:0];
    endfunction

    task automatic step(input bit en, input bit clr, input logic [59:0] w);
        chk_en = en; cnt_clr = clr; data_descrambled = w;
        @(posedge clk_div_60);
        model_edge(en, clr, w);
        #1;
    endtask

    task automatic relock();
        step(0, 0, prbs_word());
        for (int k = 0; k < 20; k++) step(1, 0, prbs_word());
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk_div_60); #1;
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %0b want 0", lock); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (err_word !== 1'b0) begin n_fail++; $display("FAIL reset_err_word: got %0b want 0", err_word); end
        n_checks++; if (bit_err_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_bit_err: got %0d want 0", bit_err_cnt); end
        n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss: got %0d want 0", lock_loss_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock();
        step(0, 0, prbs_word());
        step(0, 0, prbs_word());
        for (int k = 1; k <= 1000; k++) begin
            step(1, 0, prbs_word());
            n_checks++;
            if (lock !== (k >= 18)) begin n_fail++; $display("FAIL clean_lock edge %0d: got %0b want %0b", k, lock, k >= 18); end
            n_checks++;
            if (state !== ((k >= 18) ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL clean_state edge %0d: got %0d", k, state); end
            n_checks++;
            if (err_word !== 1'b0) begin n_fail++; $display("FAIL clean_err_word edge %0d: got 1 want 0", k); end
        end
        n_checks++; if (bit_err_cnt !== 32'd0) begin n_fail++; $display("FAIL clean_bit_err: got %0d want 0", bit_err_cnt); end
    endtask

    task automatic test_single_flip(input int pos, input int want_pulses);
        logic [59:0] w; int pulses; longint base;
        relock();
        base = m_bits; pulses = 0;
        for (int k = 0; k < 6; k++) begin
            w = prbs_word();
            if (k == 1) w[pos] = ~w[pos];
            step(1, 0, w);
            pulses += int'(err_word);
            n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL flip%0d_lock step %0d: got 0 want 1", pos, k); end
            n_checks++; if (err_word !== m_err) begin n_fail++; $display("FAIL flip%0d_err_word step %0d: got %0b want %0b", pos, k, err_word, m_err); end
        end
        n_checks++; if (pulses != want_pulses) begin n_fail++; $display("FAIL flip%0d_pulses: got %0d want %0d", pos, pulses, want_pulses); end
        n_checks++; if (bit_err_cnt !== 32'(base + 3)) begin n_fail++; $display("FAIL flip%0d_bits: got %0d want %0d", pos, bit_err_cnt, base + 3); end
    endtask

    task automatic test_loss_relock();
        logic [59:0] w; int base_loss;
        relock();
        base_loss = m_loss;
        for (int k = 0; k <= 40; k++) begin
            w = prbs_word();
            if (k == 2 || k == 6 || k == 10 || k == 14) w[59] = ~w[59];
            step(1, 0, w);
            if (k == 14) begin
                n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL loss_before: got %0d want 2", state); end
            end
            if (k == 15) begin
                n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL loss_state: got %0d want 1", state); end
                n_checks++; if (lock_loss_cnt !== 8'(base_loss + 1)) begin n_fail++; $display("FAIL loss_cnt: got %0d want %0d", lock_loss_cnt, base_loss + 1); end
            end
            if (k >= 15) begin
                n_checks++; if (lock !== (k >= 31)) begin n_fail++; $display("FAIL relock step %0d: got %0b want %0b", k, lock, k >= 31); end
            end
        end
    endtask

    task automatic test_window_wrap();
        logic [59:0] w; int base_loss;
        relock();
        base_loss = m_loss;
        for (int k = 0; k < 110; k++) begin
            w = prbs_word();
            if (k inside {58, 59, 60, 61, 75, 95}) w[59] = ~w[59];
            step(1, 0, w);
            n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL wrap_lock step %0d: got 0 want 1", k); end
            n_checks++; if (err_word !== m_err) begin n_fail++; $display("FAIL wrap_err_word step %0d: got %0b want %0b", k, err_word, m_err); end
        end
        n_checks++; if (lock_loss_cnt !== 8'(base_loss)) begin n_fail++; $display("FAIL wrap_loss: got %0d want %0d", lock_loss_cnt, base_loss); end
    endtask

    task automatic test_all_zero();
        longint base; int base_loss;
        relock();
        base = m_bits; base_loss = m_loss;
        for (int k = 0; k < 60; k++) begin
            step(1, 0, '0);
            if (k >= 1) begin
                n_checks++; if (err_word !== 1'b1) begin n_fail++; $display("FAIL zero_err_word step %0d: got 0 want 1", k); end
            end
            if (k == 3) begin
                n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL zero_still_locked: got %0d want 2", state); end
                n_checks++; if (bit_err_cnt !== 32'(base + 180)) begin n_fail++; $display("FAIL zero_bits3: got %0d want %0d", bit_err_cnt, base + 180); end
            end
            if (k >= 4) begin
                n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL zero_hunt step %0d: got %0d want 1", k, state); end
            end
        end
        n_checks++; if (bit_err_cnt !== 32'(base + 240)) begin n_fail++; $display("FAIL zero_bits: got %0d want %0d", bit_err_cnt, base + 240); end
        n_checks++; if (lock_loss_cnt !== 8'(base_loss + 1)) begin n_fail++; $display("FAIL zero_loss: got %0d want %0d", lock_loss_cnt, base_loss + 1); end
    endtask

    task automatic test_cnt_clr();
        logic [59:0] w;
        relock();
        w = prbs_word(); w[59] = ~w[59];
        step(1, 0, w);
        step(1, 1, prbs_word());
        n_checks++; if (bit_err_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_bits: got %0d want 0", bit_err_cnt); end
        n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_loss: got %0d want 0", lock_loss_cnt); end
        n_checks++; if (err_word !== 1'b1) begin n_fail++; $display("FAIL clr_err_word: got 0 want 1"); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL clr_lock: got 0 want 1"); end
        step(1, 0, prbs_word());
        n_checks++; if (bit_err_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_bits_after: got %0d want 0", bit_err_cnt); end
    endtask

    task automatic test_disable();
        relock();
        step(0, 0, prbs_word());
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL dis_lock: got 1 want 0"); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL dis_state: got %0d want 0", state); end
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, prbs_word());
            n_checks++; if (lock !== (k >= 18)) begin n_fail++; $display("FAIL dis_relock edge %0d: got %0b want %0b", k, lock, k >= 18); end
        end
    endtask

    task automatic test_saturation();
        logic [59:0] w; logic [28:0] r;
        relock();
        for (int k = 0; k < 1600; k++) begin
            w = prbs_word();
            if (k % 24 == 5) begin
                r = 29'($urandom());
                if (r == '0) r = 29'd1;
                w[59:31] = w[59:31] ^ r;
            end
            step(1, 0, w);
            n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL sat_lock step %0d: got 0 want 1", k); end
            n_checks++; if (bit_err_cnt !== exp_bits()) begin n_fail++; $display("FAIL sat_bits32 step %0d: got %0d want %0d", k, bit_err_cnt, exp_bits()); end
            n_checks++; if (s_bit_err_cnt !== exp_sat()) begin n_fail++; $display("FAIL sat_bits10 step %0d: got %0d want %0d", k, s_bit_err_cnt, exp_sat()); end
        end
        n_checks++; if (s_bit_err_cnt !== 10'h3FF) begin n_fail++; $display("FAIL sat_clamp: got %0h want 3ff", s_bit_err_cnt); end
    endtask

    task automatic test_reset_mid();
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL rmid_lock: got 1 want 0"); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d want 0", state); end
        n_checks++; if (bit_err_cnt !== 32'd0) begin n_fail++; $display("FAIL rmid_bits: got %0d want 0", bit_err_cnt); end
        n_checks++; if (s_bit_err_cnt !== '0) begin n_fail++; $display("FAIL rmid_sat_bits: got %0d want 0", s_bit_err_cnt); end
        n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_loss: got %0d want 0", lock_loss_cnt); end
        @(posedge clk_div_60); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, prbs_word());
            n_checks++; if (lock !== (k >= 18)) begin n_fail++; $display("FAIL rmid_relock edge %0d: got %0b want %0b", k, lock, k >= 18); end
        end
    endtask

    task automatic test_random();
        logic [59:0] w; logic [63:0] r64; bit en, clr;
        for (int k = 0; k < 2000; k++) begin
            en  = ($urandom_range(0, 99) != 0);
            clr = ($urandom_range(0, 49) == 0);
            w   = prbs_word();
            if ($urandom_range(0, 29) == 0) begin
                r64 = {$urandom(), $urandom()};
                w = w ^ r64[59:0];
            end
            if ($urandom_range(0, 199) == 0) w = '0;
            step(en, clr, w);
            n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state step %0d: got %0d want %0d", k, state, m_state); end
            n_checks++; if (lock !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_lock step %0d: got %0b want %0b", k, lock, m_state == 2); end
            n_checks++; if (err_word !== m_err) begin n_fail++; $display("FAIL rnd_err_word step %0d: got %0b want %0b", k, err_word, m_err); end
            n_checks++; if (bit_err_cnt !== exp_bits()) begin n_fail++; $display("FAIL rnd_bits step %0d: got %0d want %0d", k, bit_err_cnt, exp_bits()); end
            n_checks++; if (s_bit_err_cnt !== exp_sat()) begin n_fail++; $display("FAIL rnd_sat_bits step %0d: got %0d want %0d", k, s_bit_err_cnt, exp_sat()); end
            n_checks++; if (lock_loss_cnt !== 8'(m_loss)) begin n_fail++; $display("FAIL rnd_loss step %0d: got %0d want %0d", k, lock_loss_cnt, m_loss); end
        end
    endtask

    initial begin
        for (int i = 0; i < 31; i++) gen_hist.push_back(bit'($urandom_range(0, 1)));
        gen_hist[30] = 1'b1;
        test_reset();
        test_clean_lock();
        test_single_flip(59, 1);
        test_single_flip(0, 2);
        test_loss_relock();
        test_window_wrap();
        test_all_zero();
        test_cnt_clr();
        test_disable();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
